// File: rtl/warp_inflight_tracker.sv
// Per-warp outstanding-instruction tracker fed by the commit bus.
// Provides pending/idle status, issue back-pressure and a single-warp drain sequencer.
module warp_inflight_tracker #(
  parameter int unsigned NUM_WARPS = 8,
  parameter int unsigned ISSUE_CNT = 2,
  parameter int unsigned NW_WIDTH  = 3,
  parameter int unsigned CTR_WIDTH = 6
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_issue_valid,
  input  logic [NW_WIDTH-1:0]           i_issue_wid,
  output logic                          o_issue_ready,
  input  logic [ISSUE_CNT-1:0]          i_committed,
  input  logic [ISSUE_CNT*NW_WIDTH-1:0] i_committed_wid,
  input  logic                          i_drain_req,
  input  logic [NW_WIDTH-1:0]           i_drain_wid,
  output logic                          o_drain_busy,
  output logic                          o_drain_done,
  output logic [NUM_WARPS-1:0]          o_warp_pending,
  output logic                          o_all_idle,
  output logic                          o_underflow_err
);

  localparam int unsigned NXT_W = CTR_WIDTH + 2;
  localparam logic [CTR_WIDTH-1:0] CMAX = '1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [CTR_WIDTH-1:0] r_cnt [NUM_WARPS];
  logic [CTR_WIDTH-1:0] w_cnt_nxt [NUM_WARPS];
  logic [NUM_WARPS-1:0] w_under;
  logic [NUM_WARPS-1:0] w_pending_nxt;
  logic [NW_WIDTH-1:0]  r_drain_wid;
  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic                 w_latch_wid;
  logic                 w_sel_full;
  logic                 w_drain_zero;
  logic                 w_fire;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pending_any;
  logic [NUM_WARPS-1:0] r_pending;
  logic                 r_underflow;

  // Select the counter addressed by issue_wid and by the latched drain id.
  always_comb begin
    w_sel_full   = 1'b0;
    w_drain_zero = 1'b1;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      if (i_issue_wid == NW_WIDTH'(w)) w_sel_full = (r_cnt[w] == CMAX);
      if (r_drain_wid == NW_WIDTH'(w)) w_drain_zero = (r_cnt[w] == '0);
    end
  end

  assign o_issue_ready = !w_sel_full && !(r_busy && (i_issue_wid == r_drain_wid));
  assign w_fire        = i_issue_valid && o_issue_ready;

  // Counter arithmetic widened by two bits; a set MSB means the result went negative.
  always_comb begin
    logic [NXT_W-1:0] v_next;
    w_under       = '0;
    w_pending_nxt = '0;
    v_next        = '0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      v_next = {2'b00, r_cnt[w]};
      if (w_fire && (i_issue_wid == NW_WIDTH'(w))) v_next = v_next + NXT_W'(1);
      for (int unsigned i = 0; i < ISSUE_CNT; i++) begin
        if (i_committed[i] && (i_committed_wid[i*NW_WIDTH +: NW_WIDTH] == NW_WIDTH'(w)))
          v_next = v_next - NXT_W'(1);
      end
      if (v_next[NXT_W-1]) begin
        w_cnt_nxt[w] = '0;
        w_under[w]   = 1'b1;
      end else begin
        w_cnt_nxt[w] = v_next[CTR_WIDTH-1:0];
      end
      w_pending_nxt[w] = (w_cnt_nxt[w] != '0);
    end
  end

  // Drain sequencer next-state.
  always_comb begin
    w_state_nxt = r_state;
    w_latch_wid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_drain_req) begin
          w_state_nxt = S_WAIT;
          w_latch_wid = 1'b1;
        end
      end
      S_WAIT:  if (w_drain_zero) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) r_cnt[w] <= '0;
      r_state       <= S_IDLE;
      r_drain_wid   <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pending     <= '0;
      r_pending_any <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) r_cnt[w] <= w_cnt_nxt[w];
      r_state       <= w_state_nxt;
      if (w_latch_wid) r_drain_wid <= i_drain_wid;
      r_busy        <= (w_state_nxt != S_IDLE);
      r_done        <= (w_state_nxt == S_DONE);
      r_pending     <= w_pending_nxt;
      r_pending_any <= |w_pending_nxt;
      r_underflow   <= r_underflow | (|w_under);
    end
  end

  assign o_drain_busy    = r_busy;
  assign o_drain_done    = r_done;
  assign o_warp_pending  = r_pending;
  assign o_all_idle      = !r_pending_any;
  assign o_underflow_err = r_underflow;

endmodule

// File: tb/tb_warp_inflight_tracker.sv
// Bench for warp_inflight_tracker: cycle-level reference model plus directed scenarios.
module tb_warp_inflight_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid;
  logic [2:0] issue_wid;
  logic       issue_ready;
  logic [1:0] committed;
  logic [5:0] committed_wid;
  logic       drain_req;
  logic [2:0] drain_wid;
  logic       drain_busy;
  logic       drain_done;
  logic [7:0] warp_pending;
  logic       all_idle;
  logic       underflow_err;

  int n_cmp = 0;
  int n_err = 0;

  warp_inflight_tracker dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_issue_valid  (issue_valid),
    .i_issue_wid    (issue_wid),
    .o_issue_ready  (issue_ready),
    .i_committed    (committed),
    .i_committed_wid(committed_wid),
    .i_drain_req    (drain_req),
    .i_drain_wid    (drain_wid),
    .o_drain_busy   (drain_busy),
    .o_drain_done   (drain_done),
    .o_warp_pending (warp_pending),
    .o_all_idle     (all_idle),
    .o_underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer counts and a drain phase (0 idle, 1 waiting, 2 done).
  int m_cnt [8];
  int m_phase = 0;
  int m_dwid = 0;
  bit m_under = 1'b0;
  bit m_valid = 1'b0;
  bit m_fire;
  int m_n;

  function automatic bit ready_exp(int wid);
    return (m_cnt[wid] != 63) && !((m_phase != 0) && (wid == m_dwid));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < 8; w++) m_cnt[w] = 0;
      m_phase = 0;
      m_under = 1'b0;
      m_valid = 1'b1;
    end else begin
      m_fire = issue_valid && ready_exp(int'(issue_wid));
      if (m_phase == 0) begin
        if (drain_req) begin
          m_phase = 1;
          m_dwid  = int'(drain_wid);
        end
      end else if (m_phase == 1) begin
        if (m_cnt[m_dwid] == 0) m_phase = 2;
      end else begin
        m_phase = 0;
      end
      for (int w = 0; w < 8; w++) begin
        m_n = m_cnt[w];
        if (m_fire && int'(issue_wid) == w) m_n++;
        if (committed[0] && int'(committed_wid[2:0]) == w) m_n--;
        if (committed[1] && int'(committed_wid[5:3]) == w) m_n--;
        if (m_n < 0) begin
          m_n = 0;
          m_under = 1'b1;
        end
        m_cnt[w] = m_n;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [7:0] ep;
    if (m_valid) begin
      ep = '0;
      for (int w = 0; w < 8; w++) ep[w] = (m_cnt[w] != 0);
      chk("m_pending", 32'(warp_pending), 32'(ep));
      chk("m_all_idle", 32'(all_idle), 32'(ep == 8'h00));
      chk("m_underflow", 32'(underflow_err), 32'(m_under));
      chk("m_busy", 32'(drain_busy), 32'(m_phase != 0));
      chk("m_done", 32'(drain_done), 32'(m_phase == 2));
      chk("m_ready", 32'(issue_ready), 32'(ready_exp(int'(issue_wid))));
    end
  end

  task automatic cyc(input logic iv, input logic [2:0] iw, input logic [1:0] cm,
                     input logic [5:0] cw, input logic dr, input logic [2:0] dw);
    issue_valid   = iv;
    issue_wid     = iw;
    committed     = cm;
    committed_wid = cw;
    drain_req     = dr;
    drain_wid     = dw;
    @(posedge clk);
    #1;
    issue_valid   = 1'b0;
    issue_wid     = 3'd0;
    committed     = 2'b00;
    committed_wid = 6'd0;
    drain_req     = 1'b0;
    drain_wid     = 3'd0;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 3'd0, 2'b00, 6'd0, 1'b0, 3'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_cyc();
    reset = 1'b0;
  endtask

  task automatic rdy_chk(input string name, input logic [2:0] wid, input logic exp);
    issue_wid = wid;
    #1;
    chk(name, 32'(issue_ready), 32'(exp));
  endtask

  initial begin
    reset = 1'b1;
    issue_valid = 1'b0; issue_wid = 3'd0; committed = 2'b00;
    committed_wid = 6'd0; drain_req = 1'b0; drain_wid = 3'd0;
    idle_cyc();
    idle_cyc();
    reset = 1'b0;
    chk("rst_pending", 32'(warp_pending), 32'h00);
    chk("rst_all_idle", 32'(all_idle), 32'd1);
    chk("rst_busy", 32'(drain_busy), 32'd0);
    chk("rst_done", 32'(drain_done), 32'd0);
    chk("rst_underflow", 32'(underflow_err), 32'd0);
    rdy_chk("rst_ready", 3'd5, 1'b1);

    // Five issues to warp 3, then five commits on lane 0.
    cyc(1'b1, 3'd3, 2'b00, 6'd0, 1'b0, 3'd0);
    chk("t1_pending_first", 32'(warp_pending), 32'h08);
    for (int k = 0; k < 4; k++) cyc(1'b1, 3'd3, 2'b00, 6'd0, 1'b0, 3'd0);
    chk("t1_pending", 32'(warp_pending), 32'h08);
    chk("t1_model_cnt3", 32'(m_cnt[3]), 32'd5);
    chk("t1_all_idle0", 32'(all_idle), 32'd0);
    for (int k = 0; k < 4; k++) cyc(1'b0, 3'd0, 2'b01, 6'o03, 1'b0, 3'd0);
    chk("t1_pending_4c", 32'(warp_pending), 32'h08);
    cyc(1'b0, 3'd0, 2'b01, 6'o03, 1'b0, 3'd0);
    chk("t1_pending_clr", 32'(warp_pending), 32'h00);
    chk("t1_all_idle1", 32'(all_idle), 32'd1);

    // Same-cycle issue plus double commit, then underflow.
    do_reset();
    cyc(1'b1, 3'd2, 2'b00, 6'd0, 1'b0, 3'd0);
    cyc(1'b1, 3'd2, 2'b00, 6'd0, 1'b0, 3'd0);
    cyc(1'b1, 3'd2, 2'b11, 6'o22, 1'b0, 3'd0);
    chk("t2_model_cnt2", 32'(m_cnt[2]), 32'd1);
    chk("t2_pending", 32'(warp_pending), 32'h04);
    chk("t2_no_underflow", 32'(underflow_err), 32'd0);
    cyc(1'b0, 3'd0, 2'b11, 6'o22, 1'b0, 3'd0);
    chk("t2_pending_clr", 32'(warp_pending), 32'h00);
    chk("t2_underflow", 32'(underflow_err), 32'd1);
    for (int k = 0; k < 3; k++) idle_cyc();
    chk("t2_underflow_sticky", 32'(underflow_err), 32'd1);

    // Saturation of warp 0 at 63.
    do_reset();
    for (int k = 0; k < 63; k++) cyc(1'b1, 3'd0, 2'b00, 6'd0, 1'b0, 3'd0);
    rdy_chk("t3_full_w0", 3'd0, 1'b0);
    rdy_chk("t3_free_w1", 3'd1, 1'b1);
    cyc(1'b1, 3'd0, 2'b00, 6'd0, 1'b0, 3'd0);
    chk("t3_model_cnt0", 32'(m_cnt[0]), 32'd63);
    cyc(1'b0, 3'd0, 2'b10, 6'o00, 1'b0, 3'd0);
    rdy_chk("t3_ready_back", 3'd0, 1'b1);

    // Drain warp 5 with two outstanding, commits at N+3 and N+4.
    do_reset();
    cyc(1'b1, 3'd5, 2'b00, 6'd0, 1'b0, 3'd0);
    cyc(1'b1, 3'd5, 2'b00, 6'd0, 1'b0, 3'd0);
    cyc(1'b0, 3'd0, 2'b00, 6'd0, 1'b1, 3'd5);          // N
    chk("t4_busy_n1", 32'(drain_busy), 32'd1);
    rdy_chk("t4_block_w5", 3'd5, 1'b0);
    rdy_chk("t4_free_w4", 3'd4, 1'b1);
    cyc(1'b1, 3'd5, 2'b00, 6'd0, 1'b0, 3'd0);          // N+1, blocked attempt
    idle_cyc();                                         // N+2
    cyc(1'b0, 3'd0, 2'b01, 6'o05, 1'b0, 3'd0);          // N+3
    cyc(1'b0, 3'd0, 2'b10, 6'o50, 1'b0, 3'd0);          // N+4
    chk("t4_done_n5", 32'(drain_done), 32'd0);
    idle_cyc();
    chk("t4_done_n6", 32'(drain_done), 32'd1);
    chk("t4_busy_n6", 32'(drain_busy), 32'd1);
    idle_cyc();
    chk("t4_busy_n7", 32'(drain_busy), 32'd0);
    chk("t4_done_n7", 32'(drain_done), 32'd0);

    // Drain of an idle warp with an ignored second request.
    cyc(1'b0, 3'd0, 2'b00, 6'd0, 1'b1, 3'd1);          // N
    chk("t5_busy_n1", 32'(drain_busy), 32'd1);
    chk("t5_done_n1", 32'(drain_done), 32'd0);
    cyc(1'b0, 3'd0, 2'b00, 6'd0, 1'b1, 3'd2);          // N+1, ignored
    chk("t5_done_n2", 32'(drain_done), 32'd1);
    idle_cyc();
    chk("t5_busy_n3", 32'(drain_busy), 32'd0);
    chk("t5_done_n3", 32'(drain_done), 32'd0);
    idle_cyc();
    rdy_chk("t5_w2_free", 3'd2, 1'b1);

    // Reset while waiting on warp 6.
    for (int k = 0; k < 4; k++) cyc(1'b1, 3'd6, 2'b00, 6'd0, 1'b0, 3'd0);
    cyc(1'b0, 3'd0, 2'b00, 6'd0, 1'b1, 3'd6);
    idle_cyc();
    chk("t6_busy_wait", 32'(drain_busy), 32'd1);
    do_reset();
    chk("t6_all_idle", 32'(all_idle), 32'd1);
    chk("t6_busy", 32'(drain_busy), 32'd0);
    chk("t6_done", 32'(drain_done), 32'd0);
    chk("t6_pending", 32'(warp_pending), 32'h00);
    rdy_chk("t6_ready_w6", 3'd6, 1'b1);
    idle_cyc();
    chk("t6_done_after", 32'(drain_done), 32'd0);

    idle_cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
